// File: rtl/myip_axis_pkg.sv
// Shared types and helpers for the AXI4-Stream store-and-forward IP.
//   state_e  : capture/replay phase of the store-and-forward controller
//   KEEP_ALL : all-ones keep pattern, sliced to the TKEEP width by users
//   clog2    : ceiling log2 for sizing pointers and counters
package myip_axis_pkg;

  typedef enum logic {
    RECV = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [127:0] KEEP_ALL = '1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) result++;
    return result;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with a registered read port.
//   clk, rst_n   : clock, asynchronous active-low reset
//   write_en     : push input_data (ignored when full)
//   input_data   : write data
//   pop_en       : pop one word (ignored when empty); output_data valid next cycle
//   output_data  : registered read data, holds its value between pops
//   full, empty  : occupancy flags derived from the extra pointer bit
module axis_sync_fifo
  import myip_axis_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 64,
  parameter int unsigned FIFO_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       write_en,
  input  logic [FIFO_DATA_WIDTH-1:0] input_data,
  input  logic                       pop_en,
  output logic [FIFO_DATA_WIDTH-1:0] output_data,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = clog2(FIFO_DEPTH);
  localparam int unsigned PW    = PTR_W + 1;

  logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]             wr_ptr_q;
  logic [PTR_W:0]             rd_ptr_q;
  logic                       do_write;
  logic                       do_read;

  // Same index with differing wrap bits means the write pointer lapped the read pointer.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_write = write_en && !full;
  assign do_read  = pop_en && !empty;

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q[PTR_W-1:0]] <= input_data;
  end

  // Pointers and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      output_data <= '0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_read) begin
        rd_ptr_q    <= rd_ptr_q + PW'(1);
        output_data <= mem[rd_ptr_q[PTR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/myip_new_axis_store_forward.sv
// AXI4-Stream store-and-forward buffer: captures one packet (or FIFO_DEPTH
// words, whichever comes first) on the slave port, then replays it in order
// on the master port with TLAST on the final word.
//   AXIS_ACLK, AXIS_ARESETN : clock, asynchronous active-low reset
//   S_AXIS_*                : upstream stream (TKEEP ignored)
//   M_AXIS_*                : downstream stream (TKEEP all ones)
//   receive_finish          : high from capture of the last word until replay ends
module myip_new_axis_store_forward
  import myip_axis_pkg::*;
#(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned FIFO_DATA_WIDTH    = 32,
  parameter int unsigned FIFO_DEPTH         = 64
) (
  input  logic                            AXIS_ACLK,
  input  logic                            AXIS_ARESETN,
  input  logic                            S_AXIS_TVALID,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic                            S_AXIS_TLAST,
  output logic                            S_AXIS_TREADY,
  output logic                            M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                            M_AXIS_TLAST,
  input  logic                            M_AXIS_TREADY,
  output logic                            receive_finish
);

  localparam int unsigned PTR_W  = clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned KEEP_W = C_AXIS_TDATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [CNT_W-1:0] send_count_q, send_count_d;
  logic             s_tready_q, s_tready_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic             m_tlast_q, m_tlast_d;
  logic             recv_fin_q, recv_fin_d;

  logic fifo_full;
  logic fifo_empty;
  logic s_hs;
  logic m_hs;
  logic pop;
  logic unused_keep;

  assign unused_keep = ^S_AXIS_TKEEP;

  assign s_hs = S_AXIS_TVALID && s_tready_q && !fifo_full;
  assign m_hs = m_tvalid_q && M_AXIS_TREADY;
  // The FIFO read register is the output register: refill when it drains.
  assign pop  = (state_q == SEND) && (!m_tvalid_q || m_hs) && !fifo_empty;

  axis_sync_fifo #(
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_DATA_WIDTH (FIFO_DATA_WIDTH)
  ) u_fifo (
    .clk         (AXIS_ACLK),
    .rst_n       (AXIS_ARESETN),
    .write_en    (s_hs),
    .input_data  (S_AXIS_TDATA),
    .pop_en      (pop),
    .output_data (M_AXIS_TDATA),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    send_count_d = send_count_q;
    s_tready_d   = s_tready_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    recv_fin_d   = recv_fin_q;
    case (state_q)
      RECV: begin
        if (s_hs) begin
          word_count_d = word_count_q + CNT_W'(1);
          // Filling the FIFO ends the packet early; the rest waits for the next capture.
          if (S_AXIS_TLAST || (word_count_d == DEPTH_C)) begin
            state_d    = SEND;
            recv_fin_d = 1'b1;
            s_tready_d = 1'b0;
          end
        end
      end
      SEND: begin
        if (pop) begin
          send_count_d = send_count_q + CNT_W'(1);
          m_tvalid_d   = 1'b1;
          m_tlast_d    = (send_count_d == word_count_q);
        end else if (m_hs) begin
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
        end
        if (m_hs && m_tlast_q) begin
          state_d      = RECV;
          word_count_d = '0;
          send_count_d = '0;
          recv_fin_d   = 1'b0;
          s_tready_d   = 1'b1;
          m_tvalid_d   = 1'b0;
          m_tlast_d    = 1'b0;
        end
      end
      default: state_d = RECV;
    endcase
  end

  // State and output registers.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q      <= RECV;
      word_count_q <= '0;
      send_count_q <= '0;
      s_tready_q   <= 1'b1;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      recv_fin_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      send_count_q <= send_count_d;
      s_tready_q   <= s_tready_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      recv_fin_q   <= recv_fin_d;
    end
  end

  assign S_AXIS_TREADY  = s_tready_q;
  assign M_AXIS_TVALID  = m_tvalid_q;
  assign M_AXIS_TLAST   = m_tlast_q;
  assign M_AXIS_TKEEP   = KEEP_ALL[KEEP_W-1:0];
  assign receive_finish = recv_fin_q;

endmodule

// File: tb/tb_myip_new_axis_store_forward.sv
// Self-checking bench for myip_new_axis_store_forward: a cycle-by-cycle
// vector table for a short packet, then directed packet sequences.
module tb_myip_new_axis_store_forward;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last;
  logic        S_AXIS_TREADY;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TLAST;
  logic        m_ready;
  logic        receive_finish;

  int n_checks = 0;
  int n_fail   = 0;

  myip_new_axis_store_forward #(
    .C_AXIS_TDATA_WIDTH (32),
    .FIFO_DATA_WIDTH    (32),
    .FIFO_DEPTH         (64)
  ) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (rst_n),
    .S_AXIS_TVALID  (s_valid),
    .S_AXIS_TDATA   (s_data),
    .S_AXIS_TKEEP   (s_keep),
    .S_AXIS_TLAST   (s_last),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TKEEP   (M_AXIS_TKEEP),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .M_AXIS_TREADY  (m_ready),
    .receive_finish (receive_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sv;
    logic [31:0] sd;
    logic        sl;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic [31:0] e_md;
    logic        e_ml;
    logic        e_rf;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or protocol broken (t=%0t)", name, $time);
  endtask

  function automatic logic ready_pat(input int k);
    if (k < 5)  return 1'b0;
    if (k == 5) return 1'b1;
    if (k < 21) return 1'b0;
    if (k < 58) return 1'b1;
    if (k < 78) return 1'b0;
    return 1'b1;
  endfunction

  // Drive n words first..first+n-1; called and returns at a negedge.
  task automatic drive_words(input int first, input int n, input bit last_at_end, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int waited;
      waited = 0;
      if (gaps && i > 0) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = 32'(first + i);
      s_last  = last_at_end && (i == n - 1);
      while (!S_AXIS_TREADY && waited < 2000) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 2000) begin
        fail_now("drive_timeout");
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Accept n_take words expected to be first.. in order, with TLAST on word n_total.
  task automatic collect(input int first, input int n_take, input int n_total, input bit stall);
    int got, cyc, k;
    bit started, hold;
    logic [31:0] held;
    got = 0; cyc = 0; k = 0; started = 0; hold = 0; held = '0;
    while (got < n_take && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (M_AXIS_TVALID) started = 1;
      m_ready = (stall && started) ? ready_pat(k) : 1'b1;
      if (started) k++;
      if (hold) begin
        check("hold_data", M_AXIS_TDATA, held);
        check("hold_valid", 32'(M_AXIS_TVALID), 32'd1);
      end
      hold = 0;
      if (M_AXIS_TVALID && m_ready) begin
        check("data", M_AXIS_TDATA, 32'(first + got));
        check("last", 32'(M_AXIS_TLAST), 32'(got == n_total - 1));
        check("rf_busy", 32'(receive_finish), 32'd1);
        check("s_ready_off", 32'(S_AXIS_TREADY), 32'd0);
        got++;
      end else if (M_AXIS_TVALID) begin
        hold = 1;
        held = M_AXIS_TDATA;
      end else if (started) begin
        fail_now("valid_dropped");
      end
    end
    if (got < n_take) fail_now("collect_timeout");
  endtask

  task automatic post_check();
    @(negedge clk);
    check("post_valid", 32'(M_AXIS_TVALID), 32'd0);
    check("post_rf", 32'(receive_finish), 32'd0);
    check("post_s_ready", 32'(S_AXIS_TREADY), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Three-word packet 11,22,(gap),33 then a stalled replay.
    //           sv   sd      sl  mr   sr  mv  md      ml  rf
    vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 32'h33, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h33, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0};

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = 4'hF; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(M_AXIS_TVALID), 32'd0);
    check("rst_last", 32'(M_AXIS_TLAST), 32'd0);
    check("rst_data", M_AXIS_TDATA, 32'd0);
    check("rst_rf", 32'(receive_finish), 32'd0);
    check("keep_all", 32'(M_AXIS_TKEEP), 32'hF);
    rst_n = 1'b1;

    // Cycle-by-cycle vector table.
    for (int i = 0; i < 11; i++) begin
      s_valid = vecs[i].sv; s_data = vecs[i].sd; s_last = vecs[i].sl; m_ready = vecs[i].mr;
      check($sformatf("vec%0d_s_ready", i), 32'(S_AXIS_TREADY), 32'(vecs[i].e_sr));
      check($sformatf("vec%0d_m_valid", i), 32'(M_AXIS_TVALID), 32'(vecs[i].e_mv));
      check($sformatf("vec%0d_m_last", i), 32'(M_AXIS_TLAST), 32'(vecs[i].e_ml));
      check($sformatf("vec%0d_rf", i), 32'(receive_finish), 32'(vecs[i].e_rf));
      if (vecs[i].e_mv || i == 0)
        check($sformatf("vec%0d_m_data", i), M_AXIS_TDATA, vecs[i].e_md);
      @(negedge clk);
    end

    // Single-word packet: latency of receive_finish and TVALID, TREADY return.
    s_valid = 1'b1; s_data = 32'hA5A5A5A5; s_last = 1'b1; m_ready = 1'b1;
    check("single_s_ready", 32'(S_AXIS_TREADY), 32'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    check("single_rf_rise", 32'(receive_finish), 32'd1);
    check("single_s_ready_off", 32'(S_AXIS_TREADY), 32'd0);
    check("single_valid_wait", 32'(M_AXIS_TVALID), 32'd0);
    @(negedge clk);
    check("single_valid", 32'(M_AXIS_TVALID), 32'd1);
    check("single_data", M_AXIS_TDATA, 32'hA5A5A5A5);
    check("single_last", 32'(M_AXIS_TLAST), 32'd1);
    @(negedge clk);
    check("single_valid_off", 32'(M_AXIS_TVALID), 32'd0);
    check("single_rf_off", 32'(receive_finish), 32'd0);
    check("single_s_ready_back", 32'(S_AXIS_TREADY), 32'd1);

    // 50 words, downstream always ready.
    fork
      drive_words(1, 50, 1'b1, 1'b0);
      collect(1, 50, 50, 1'b0);
    join
    post_check();

    // 50 words with the downstream stall pattern.
    fork
      drive_words(1, 50, 1'b1, 1'b0);
      collect(1, 50, 50, 1'b1);
    join
    post_check();

    // 50 words with valid every other cycle.
    fork
      drive_words(1, 50, 1'b1, 1'b1);
      collect(1, 50, 50, 1'b0);
    join
    post_check();

    // 70-word packet truncated at 64; the tail becomes a second packet.
    fork
      drive_words(1, 70, 1'b1, 1'b0);
      begin
        collect(1, 64, 64, 1'b0);
        collect(65, 6, 6, 1'b0);
      end
    join
    post_check();

    // Reset in the middle of a replay, then a fresh 3-word packet.
    fork
      drive_words(1, 50, 1'b1, 1'b0);
      collect(1, 20, 50, 1'b0);
    join
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("midrst_valid", 32'(M_AXIS_TVALID), 32'd0);
    check("midrst_rf", 32'(receive_finish), 32'd0);
    check("midrst_last", 32'(M_AXIS_TLAST), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_s_ready", 32'(S_AXIS_TREADY), 32'd1);
    fork
      drive_words(32'h100, 3, 1'b1, 1'b0);
      collect(32'h100, 3, 3, 1'b0);
    join
    post_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
